// File: rtl/instr_fifo_pkg.sv
// Shared constants and helpers for the instruction FIFO and the decoder front end.
package instr_fifo_pkg;

    localparam int DEF_DATA_W = 13;
    localparam int DEF_ADDR_W = 3;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction

    localparam int DEF_COUNT_W = count_w(DEF_ADDR_W);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/instr_fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, asynchronous read.
module instr_fifo_mem #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fifo_param.sv
// Parametrised instruction FIFO with almost flags, flush and sticky error flags.
// Define INSTR_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module instr_fifo_param
    import instr_fifo_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int CNT_W = count_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_AFULL  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0]  CNT_AEMPTY = CNT_W'(AEMPTY_THRESH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_acc;
    logic              rd_acc;
    fifo_op_e          op;

    assign empty        = (count == '0);
    assign full         = (count == CNT_DEPTH);
    assign almost_empty = (count <= CNT_AEMPTY);
    assign almost_full  = (count >= CNT_AFULL);

    // Acceptance is qualified by reset and flush so the RAM never sees a write in those cycles.
    assign wr_acc = rst_n & ~flush & wr_en & ~full;
    assign rd_acc = rst_n & ~flush & rd_en & ~empty;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    instr_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf_err <= 1'b1;
            end
            if (rd_en && empty) begin
                udf_err <= 1'b1;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (op)
                OP_WRITE: count <= count + CNT_ONE;
                OP_READ:  count <= count - CNT_ONE;
                default:  count <= count;
            endcase
        end
    end

`ifdef INSTR_FIFO_FWFT_EN
    // Head word is presented directly; rd_en only pops.
    assign rd_data  = mem_rdata;
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem_rdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fifo_param.sv
// Self-checking bench for instr_fifo_param: directed scenarios then randomized traffic vs a queue model.
module tb_instr_fifo_param;

    localparam int DATA_W = 13;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              ovf_err;
    logic              udf_err;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] expRdData;
    logic              expRdValid;
    logic              expOvf;
    logic              expUdf;

    int nVectors = 0;
    int nMiscompares = 0;

    instr_fifo_param #(
        .DATA_W        (DATA_W),
        .ADDR_W        (ADDR_W),
        .AFULL_THRESH  (6),
        .AEMPTY_THRESH (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int n;
        n = q.size();
        checkVal("count", 32'(count), 32'(n));
        checkVal("empty", 32'(empty), 32'(n == 0));
        checkVal("full", 32'(full), 32'(n == DEPTH));
        checkVal("almost_empty", 32'(almost_empty), 32'(n <= 1));
        checkVal("almost_full", 32'(almost_full), 32'(n >= 6));
        checkVal("ovf_err", 32'(ovf_err), 32'(expOvf));
        checkVal("udf_err", 32'(udf_err), 32'(expUdf));
`ifdef INSTR_FIFO_FWFT_EN
        checkVal("rd_valid", 32'(rd_valid), 32'(n != 0));
        if (n != 0) begin
            checkVal("rd_data", 32'(rd_data), 32'(q[0]));
        end
`else
        checkVal("rd_valid", 32'(rd_valid), 32'(expRdValid));
        checkVal("rd_data", 32'(rd_data), 32'(expRdData));
`endif
    endtask

    // Drive one cycle, advance the model from the pre-edge occupancy, then check after the edge.
    task automatic applyStimulus(input logic rstv, input logic fl, input logic wr, input logic rd,
                                 input logic [DATA_W-1:0] d);
        bit wasFull;
        bit wasEmpty;
        rst_n   = rstv;
        flush   = fl;
        wr_en   = wr;
        rd_en   = rd;
        wr_data = d;
        wasFull  = (q.size() == DEPTH);
        wasEmpty = (q.size() == 0);
        if (!rstv) begin
            q.delete();
            expOvf     = 1'b0;
            expUdf     = 1'b0;
            expRdData  = '0;
            expRdValid = 1'b0;
        end else if (fl) begin
            q.delete();
            expOvf     = 1'b0;
            expUdf     = 1'b0;
            expRdValid = 1'b0;
        end else begin
            if (wr && wasFull) expOvf = 1'b1;
            if (rd && wasEmpty) expUdf = 1'b1;
            expRdValid = rd && !wasEmpty;
            if (rd && !wasEmpty) expRdData = q.pop_front();
            if (wr && !wasFull) q.push_back(d);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int r;
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        expOvf = 1'b0; expUdf = 1'b0; expRdData = '0; expRdValid = 1'b0;
        #2;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Fill 1..8, one extra write while full, drain, one extra read while empty
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DATA_W'(i));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 13'h0009);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Steady simultaneous traffic at count 4 with pointer wrap
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DATA_W'($urandom));
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, DATA_W'($urandom));

        // wr+rd at full drops the write; wr+rd at empty drops the read
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DATA_W'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 13'h1111);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 13'h0AAA);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Flush at count 5 with ovf_err set, concurrent write ignored
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DATA_W'($urandom));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 13'h1FFF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 13'h1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Head word visibility the cycle after the write, then pop
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 13'h1ABC);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Reset mid-operation discards contents
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DATA_W'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 13'h0555);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            applyStimulus(r != 0, (r == 1) || (r == 2), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), DATA_W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
